lc3_mem_arbiter: RTL and testbench
==================================

// Module: lc3_mem_arbiter
// PURPOSE
//  Shares one single-port memory between the LC3 fetch port (pc/instrmem_rd) and the MemAccess data port.
//  Sits between the LC3 core and the memory model; sequences one access at a time.
//  Returns Instr_dout/complete_instr and Data_dout/complete_data. Includes an anti-starvation counter and a stall watchdog.
// PARAMETERS
//  ADDR_W      16    address width
//  DATA_W      16    data width
//  STARVE_MAX  4     consecutive data grants allowed while fetch waits
//  TIMEOUT     1000  cycles in BUSY without mem_ack before abort
// PORTS
//  clock           in   1       single clock, rising edge
//  reset           in   1       asynchronous, active-low reset
//  instrmem_rd     in   1       fetch request; held until complete_instr
//  pc              in   ADDR_W  fetch address
//  Instr_dout      out  DATA_W  fetched word
//  complete_instr  out  1       1-cycle fetch-done pulse
//  data_req        in   1       data request; held until complete_data
//  Data_rd         in   1       1=read, 0=write
//  Data_addr       in   ADDR_W  data address
//  Data_din        in   DATA_W  write data
//  Data_dout       out  DATA_W  read data
//  complete_data   out  1       1-cycle data-done pulse
//  mem_req         out  1       memory request, held until mem_ack
//  mem_we          out  1       memory write enable
//  mem_addr        out  ADDR_W  memory address
//  mem_wdata       out  DATA_W  memory write data
//  mem_rdata       in   DATA_W  memory read data, valid with mem_ack
//  mem_ack         in   1       access done; sampled only while mem_req=1
//  timeout_err     out  1       sticky watchdog flag
// BEHAVIOUR
//  Reset (async, reset=0):
//   - All outputs 0; FSM=IDLE; starve_cnt=0; timer=0.
//   - mem_req drops immediately, even mid-access. No completion is reported for the killed access.
//  FSM states: IDLE, BUSY_I, BUSY_D, DONE.
//  IDLE arbitration:
//   - Data wins unless instrmem_rd=1 and starve_cnt==STARVE_MAX; then fetch wins.
//   - Lone requester wins. No request: stay in IDLE.
//  Grant (IDLE->BUSY_x):
//   - Register mem_addr, mem_we and mem_wdata; assert mem_req the next cycle.
//   - Fetch: mem_we=0, mem_wdata=0. Data: mem_we=~Data_rd, mem_wdata=Data_din.
//   - mem_* are stable for the whole BUSY state.
//  BUSY_x on mem_ack:
//   - Go to DONE, drop mem_req, latch mem_rdata into Instr_dout or Data_dout (writes leave Data_dout unchanged).
//   - Pulse the matching complete_* for exactly the DONE cycle.
//  DONE: no arbitration (requester is still holding its request); always go to IDLE.
//  Minimum access: request in cycle N, mem_ack in N+1, complete in N+2, next grant in N+3.
//  Request deasserted during BUSY: ignored; the access completes and still pulses complete_*.
//  starve_cnt:
//   - +1 on each data grant while instrmem_rd=1; saturates at STARVE_MAX.
//   - Cleared on a fetch grant, or when instrmem_rd=0 at a data grant.
//  Watchdog:
//   - Counts cycles in BUSY and clears on leaving BUSY.
//   - At TIMEOUT cycles: set timeout_err (sticky until reset), drop mem_req, go to IDLE with no complete_*.
//   - A request still held is re-arbitrated.
//  Dout registers hold their value until the next completion on the same port.
//  Addresses pass unmodified (no wrap or offset logic).
// STRUCTURE
//  Package lc3_arb_pkg: arb_state_e {IDLE,BUSY_I,BUSY_D,DONE}; grant_e {GNT_I,GNT_D}; default widths and constants.
//  Sub-module lc3_arb_watchdog:
//   - Inputs: clear, enable. Output: expire.
//   - Counter width $clog2(TIMEOUT+1).
//  Arbitration, FSM and output registers live in lc3_mem_arbiter.
// TESTING
//  1. Fetch pc=16'h3000, memory returns 16'h1234 after 2 cycles -> mem_addr=3000, mem_we=0, Instr_dout=1234, one complete_instr pulse.
//  2. Fetch and data write (Data_addr=16'h4000, Data_din=16'hBEEF) in the same cycle -> data granted first with mem_we=1; fetch served next.
//  3. Fetch held while data_req stays high -> 4 data grants, then fetch grant (starve_cnt=STARVE_MAX), then data resumes.
//  4. mem_ack never returns -> timeout_err=1 after 1000 BUSY cycles; mem_req=0; no complete_*; held request re-issued.
//  5. reset asserted while BUSY_D -> mem_req=0 asynchronously; all outputs 0; after release the first request is granted normally.
//  6. Data read 16'h3005 returns 16'h00FF, then a write -> Data_dout stays 00FF after the write completes.

Source files
------------

// File: rtl/lc3_arb_pkg.sv
// Shared types, default widths and the arbitration rule for the LC3 memory arbiter.
package lc3_arb_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int DATA_W_DEF     = 16;
  localparam int STARVE_MAX_DEF = 4;
  localparam int TIMEOUT_DEF    = 1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  // Data wins unless a waiting fetch has hit the starvation limit; only valid when some request is present.
  function automatic grant_e pick_grant(input logic fetch_req, input logic data_req, input logic starved);
    if (data_req && !(fetch_req && starved)) begin
      return GNT_D;
    end else begin
      return GNT_I;
    end
  endfunction

endpackage

// File: rtl/lc3_arb_watchdog.sv
// Stall watchdog: counts cycles while enabled and flags expiry on the TIMEOUT-th cycle.
module lc3_arb_watchdog
  import lc3_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_r;

  assign expire = enable & (cnt_r == LAST);

  // Cycle counter; holds at the expiry value until the owner leaves BUSY and clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable && !expire) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Arbitrates the LC3 fetch and data ports onto one single-port memory, one access at a time,
// with fetch anti-starvation and a watchdog that aborts accesses the memory never acknowledges.
module lc3_mem_arbiter
  import lc3_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instrmem_rd,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] Instr_dout,
  output logic              complete_instr,
  input  logic              data_req,
  input  logic              Data_rd,
  input  logic [ADDR_W-1:0] Data_addr,
  input  logic [DATA_W-1:0] Data_din,
  output logic [DATA_W-1:0] Data_dout,
  output logic              complete_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              timeout_err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_e        state_r, state_s;
  grant_e            gnt_s;
  logic [SW-1:0]     starve_r, starve_s;
  logic              mem_req_r, mem_req_s;
  logic              mem_we_r, mem_we_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
  logic [DATA_W-1:0] instr_dout_r, instr_dout_s;
  logic [DATA_W-1:0] data_dout_r, data_dout_s;
  logic              cmp_i_r, cmp_i_s;
  logic              cmp_d_r, cmp_d_s;
  logic              timeout_r, timeout_s;
  logic              busy_s;
  logic              expire_s;

  assign busy_s = (state_r == BUSY_I) || (state_r == BUSY_D);
  assign gnt_s  = pick_grant(instrmem_rd, data_req, starve_r == STARVE_LIM);

  lc3_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (!busy_s),
    .enable (busy_s),
    .expire (expire_s)
  );

  // Next-state and next-register computation for arbitration, access sequencing and completion.
  always_comb begin
    state_s      = state_r;
    starve_s     = starve_r;
    mem_req_s    = mem_req_r;
    mem_we_s     = mem_we_r;
    mem_addr_s   = mem_addr_r;
    mem_wdata_s  = mem_wdata_r;
    instr_dout_s = instr_dout_r;
    data_dout_s  = data_dout_r;
    cmp_i_s      = 1'b0;
    cmp_d_s      = 1'b0;
    timeout_s    = timeout_r;

    case (state_r)
      IDLE: begin
        if (instrmem_rd || data_req) begin
          mem_req_s = 1'b1;
          case (gnt_s)
            GNT_D: begin
              state_s     = BUSY_D;
              mem_we_s    = ~Data_rd;
              mem_addr_s  = Data_addr;
              mem_wdata_s = Data_din;
              // Only data grants that make a fetch wait count toward starvation.
              if (!instrmem_rd) begin
                starve_s = '0;
              end else if (starve_r != STARVE_LIM) begin
                starve_s = starve_r + 1'b1;
              end else begin
                starve_s = starve_r;
              end
            end
            GNT_I: begin
              state_s     = BUSY_I;
              mem_we_s    = 1'b0;
              mem_addr_s  = pc;
              mem_wdata_s = '0;
              starve_s    = '0;
            end
            default: begin
              state_s   = IDLE;
              mem_req_s = 1'b0;
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack && mem_req_r) begin
          state_s   = DONE;
          mem_req_s = 1'b0;
          if (state_r == BUSY_I) begin
            instr_dout_s = mem_rdata;
            cmp_i_s      = 1'b1;
          end else begin
            cmp_d_s = 1'b1;
            if (!mem_we_r) begin
              data_dout_s = mem_rdata;
            end else begin
              data_dout_s = data_dout_r;
            end
          end
        end else if (expire_s) begin
          // Abandon the access silently; a still-held request is re-arbitrated from IDLE.
          state_s   = IDLE;
          mem_req_s = 1'b0;
          timeout_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s   = IDLE;
        mem_req_s = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers; reset kills any in-flight access immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_r     <= '0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      instr_dout_r <= '0;
      data_dout_r  <= '0;
      cmp_i_r      <= 1'b0;
      cmp_d_r      <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      starve_r     <= starve_s;
      mem_req_r    <= mem_req_s;
      mem_we_r     <= mem_we_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      instr_dout_r <= instr_dout_s;
      data_dout_r  <= data_dout_s;
      cmp_i_r      <= cmp_i_s;
      cmp_d_r      <= cmp_d_s;
      timeout_r    <= timeout_s;
    end
  end

  assign mem_req        = mem_req_r;
  assign mem_we         = mem_we_r;
  assign mem_addr       = mem_addr_r;
  assign mem_wdata      = mem_wdata_r;
  assign Instr_dout     = instr_dout_r;
  assign Data_dout      = data_dout_r;
  assign complete_instr = cmp_i_r;
  assign complete_data  = cmp_d_r;
  assign timeout_err    = timeout_r;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed plus randomized bench for lc3_mem_arbiter with a memory responder and a transaction-level model.
module tb_lc3_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instrmem_rd = 1'b0, data_req = 1'b0, Data_rd = 1'b0, mem_ack = 1'b0;
  logic [15:0] pc = 16'h0, Data_addr = 16'h0, Data_din = 16'h0, mem_rdata = 16'h0;
  logic [15:0] Instr_dout, Data_dout, mem_addr, mem_wdata;
  logic        complete_instr, complete_data, mem_req, mem_we, timeout_err;

  int checks = 0, failures = 0;
  int cyc = 0, ci_cnt = 0, cd_cnt = 0, ci_time = 0, cd_time = 0;
  int lat = 1, busy_cnt = 0;
  bit stall_mem = 1'b0, auto_drop_d = 1'b1;
  logic prev_ci = 1'b0, prev_cd = 1'b0, prev_req = 1'b0;
  logic [32:0] prev_bus = '0;
  logic [15:0] mem_model [logic [15:0]];
  logic [15:0] snap [logic [15:0]];
  acc_t acc_q[$];
  acc_t exp_q[$];

  lc3_mem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .STARVE_MAX(4), .TIMEOUT(1000)
  ) dut (
    .clock(clk), .reset(rst_n),
    .instrmem_rd(instrmem_rd), .pc(pc), .Instr_dout(Instr_dout), .complete_instr(complete_instr),
    .data_req(data_req), .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
    .Data_dout(Data_dout), .complete_data(complete_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic acc_t mk(input logic we, input logic [15:0] a, input logic [15:0] w);
    acc_t e;
    e.we = we; e.addr = a; e.wdata = w;
    return e;
  endfunction

  function automatic acc_t acc_at(input int i);
    if (i < acc_q.size()) return acc_q[i];
    else return '1;
  endfunction

  function automatic logic [15:0] mem_get(input logic [15:0] a);
    return mem_model.exists(a) ? mem_model[a] : (a ^ 16'hA5A5);
  endfunction

  function automatic logic [15:0] snap_get(input logic [15:0] a);
    return snap.exists(a) ? snap[a] : (a ^ 16'hA5A5);
  endfunction

  // One clock: observe DUT after the edge, track completions, then play the memory.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (complete_instr) begin
      chk("ci_pulse_width", 64'(prev_ci), 64'h0);
      ci_cnt++; ci_time = cyc; instrmem_rd = 1'b0;
    end
    if (complete_data) begin
      chk("cd_pulse_width", 64'(prev_cd), 64'h0);
      cd_cnt++; cd_time = cyc;
      if (auto_drop_d) data_req = 1'b0;
    end
    prev_ci = complete_instr;
    prev_cd = complete_data;
    if (mem_req && prev_req) chk("mem_stable", 64'({mem_we, mem_addr, mem_wdata}), 64'(prev_bus));
    prev_req = mem_req;
    prev_bus = {mem_we, mem_addr, mem_wdata};
    if (mem_req && !stall_mem && !mem_ack) begin
      busy_cnt++;
      if (busy_cnt >= lat) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          mem_model[mem_addr] = mem_wdata;
          mem_rdata = 16'($urandom);
        end else begin
          mem_rdata = mem_get(mem_addr);
        end
        acc_q.push_back(mk(mem_we, mem_addr, mem_wdata));
      end else begin
        mem_rdata = 16'($urandom);
      end
    end else begin
      mem_ack = 1'b0;
      busy_cnt = 0;
      mem_rdata = 16'($urandom);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((instrmem_rd || data_req) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 64'({instrmem_rd, data_req}), 64'h0);
    instrmem_rd = 1'b0;
    data_req = 1'b0;
    tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, 64'({mem_req, mem_we, complete_instr, complete_data, timeout_err}), 64'h0);
    chk({tag, "_bus"}, {mem_addr, mem_wdata, Instr_dout, Data_dout}, 64'h0);
  endtask

  initial begin
    int k, ci0, cd0, n, hi, m_starve;
    logic [15:0] m_instr, m_data;
    mem_model[16'h3000] = 16'h1234;
    mem_model[16'h3005] = 16'h00FF;

    // Reset state
    tick(); tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();
    check_zero("idle_after_reset");

    // T1: single fetch, memory answers after 2 cycles
    lat = 2; acc_q.delete(); ci0 = ci_cnt; k = cyc;
    instrmem_rd = 1'b1; pc = 16'h3000;
    tick();
    chk("t1_bus", 64'({mem_req, mem_we, mem_addr, mem_wdata}), 64'({1'b1, 1'b0, 16'h3000, 16'h0}));
    wait_idle("t1", 20);
    chk("t1_instr", 64'(Instr_dout), 64'h1234);
    chk("t1_count", 64'(ci_cnt - ci0), 64'd1);
    chk("t1_latency", 64'(ci_time - k), 64'd3);

    // T2: simultaneous fetch and data write, data goes first
    lat = 1; acc_q.delete();
    instrmem_rd = 1'b1; pc = 16'h3001;
    data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h4000; Data_din = 16'hBEEF;
    wait_idle("t2", 30);
    chk("t2_n", 64'(acc_q.size()), 64'd2);
    chk("t2_first", 64'(acc_at(0)), 64'(mk(1'b1, 16'h4000, 16'hBEEF)));
    chk("t2_second", 64'(acc_at(1)), 64'(mk(1'b0, 16'h3001, 16'h0)));
    chk("t2_instr", 64'(Instr_dout), 64'(16'h3001 ^ 16'hA5A5));

    // T3: fetch starved by a permanently held data read
    acc_q.delete(); auto_drop_d = 1'b0; ci0 = ci_cnt;
    instrmem_rd = 1'b1; pc = 16'h3002;
    data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h4100; Data_din = 16'h0;
    n = 0;
    while (ci_cnt == ci0 && n < 80) begin tick(); n++; end
    cd0 = cd_cnt; n = 0;
    while (cd_cnt == cd0 && n < 20) begin tick(); n++; end
    data_req = 1'b0; auto_drop_d = 1'b1;
    wait_idle("t3", 10);
    chk("t3_n", 64'(acc_q.size()), 64'd6);
    for (int i = 0; i < 4; i++) chk("t3_data_first", 64'(acc_at(i)), 64'(mk(1'b0, 16'h4100, 16'h0)));
    chk("t3_fetch5", 64'(acc_at(4)), 64'(mk(1'b0, 16'h3002, 16'h0)));
    chk("t3_data_resume", 64'(acc_at(5)), 64'(mk(1'b0, 16'h4100, 16'h0)));

    // T4: memory never acknowledges -> watchdog
    stall_mem = 1'b1; cd0 = cd_cnt;
    data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h4200; Data_din = 16'h5A5A;
    tick();
    hi = 0;
    while (mem_req && hi < 1100) begin hi++; tick(); end
    chk("t4_busy_cycles", 64'(hi), 64'd1000);
    chk("t4_abort", 64'({mem_req, timeout_err, complete_data}), 64'({1'b0, 1'b1, 1'b0}));
    chk("t4_no_complete", 64'(cd_cnt - cd0), 64'd0);
    tick();
    chk("t4_reissue", 64'({mem_req, mem_we, mem_addr}), 64'({1'b1, 1'b1, 16'h4200}));
    acc_q.delete(); stall_mem = 1'b0;
    wait_idle("t4", 10);
    chk("t4_after", 64'(acc_at(0)), 64'(mk(1'b1, 16'h4200, 16'h5A5A)));
    chk("t4_sticky", 64'(timeout_err), 64'h1);

    // T5: reset in the middle of a data access
    stall_mem = 1'b1; cd0 = cd_cnt;
    data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h4300; Data_din = 16'h7777;
    tick(); tick();
    chk("t5_busy", 64'(mem_req), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check_zero("t5_async");
    data_req = 1'b0; stall_mem = 1'b0;
    tick(); tick();
    check_zero("t5_held");
    rst_n = 1'b1;
    tick();
    chk("t5_no_complete", 64'(cd_cnt - cd0), 64'd0);
    acc_q.delete(); lat = 1; k = cyc;
    data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h4000; Data_din = 16'h0;
    wait_idle("t5", 10);
    chk("t5_read", 64'(Data_dout), 64'hBEEF);
    chk("t5_min_latency", 64'(cd_time - k), 64'd2);
    chk("t5_access", 64'(acc_at(0)), 64'(mk(1'b0, 16'h4000, 16'h0)));

    // T6: a write leaves Data_dout holding the last read
    data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h3005; Data_din = 16'h0;
    wait_idle("t6r", 10);
    chk("t6_read", 64'(Data_dout), 64'h00FF);
    cd0 = cd_cnt;
    data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h3006; Data_din = 16'h1111;
    wait_idle("t6w", 10);
    chk("t6_write_done", 64'(cd_cnt - cd0), 64'd1);
    chk("t6_hold", 64'(Data_dout), 64'h00FF);

    // Randomized rounds against a transaction-level model
    m_starve = 0; m_instr = 16'h0; m_data = 16'h00FF;
    for (int r = 0; r < 25; r++) begin
      logic f, d, drd;
      logic [15:0] fa, da, din;
      f = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      if (!f && !d) d = 1'b1;
      fa = 16'h3000 | 16'($urandom_range(0, 15));
      da = 16'h3000 | 16'($urandom_range(0, 15));
      drd = 1'($urandom_range(0, 1));
      din = 16'($urandom);
      lat = $urandom_range(1, 3);
      snap = mem_model;
      exp_q.delete();
      if (d && !(f && m_starve == 4)) begin
        exp_q.push_back(mk(!drd, da, din));
        if (drd) m_data = snap_get(da); else snap[da] = din;
        m_starve = f ? ((m_starve < 4) ? m_starve + 1 : 4) : 0;
        if (f) begin
          exp_q.push_back(mk(1'b0, fa, 16'h0));
          m_instr = snap_get(fa);
          m_starve = 0;
        end
      end else begin
        exp_q.push_back(mk(1'b0, fa, 16'h0));
        m_instr = snap_get(fa);
        m_starve = 0;
        if (d) begin
          exp_q.push_back(mk(!drd, da, din));
          if (drd) m_data = snap_get(da); else snap[da] = din;
        end
      end
      ci0 = ci_cnt; cd0 = cd_cnt; acc_q.delete();
      instrmem_rd = f; pc = fa;
      data_req = d; Data_rd = drd; Data_addr = da; Data_din = din;
      wait_idle("rnd", 40);
      chk("rnd_n", 64'(acc_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) chk("rnd_acc", 64'(acc_at(i)), 64'(exp_q[i]));
      chk("rnd_instr", 64'(Instr_dout), 64'(m_instr));
      chk("rnd_data", 64'(Data_dout), 64'(m_data));
      chk("rnd_counts", 64'({ci_cnt - ci0, cd_cnt - cd0}), 64'({32'(f), 32'(d)}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
